// File: rtl/frame_strobe_ctrl.sv
// frame_strobe_ctrl
//   Bottom-of-column configuration controller. Turns a stream of 32-bit
//   configuration words into per-row FrameData and a one-hot, single-cycle
//   FrameStrobe that daisy-chains up through the tiles of a fabric column.
//
//   Word stream: sync (FAB0_FAB1), then any number of frames, each a header
//   (0xC0 in the top byte, frame index in [20:16]) followed by NumRows data
//   words. A desync word (FAB0_FAB0) in place of a header ends the session.
//
// Ports
//   CLK          configuration clock, rising edge
//   resetn       asynchronous active-low reset
//   WriteData    configuration word
//   WriteStrobe  WriteData valid this cycle (always consumed)
//   FrameData    row data, row k at [k*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  one-hot single-cycle frame write pulse
//   ConfigBusy   high while not in IDLE
//   ConfigError  sticky bad-header / out-of-range frame error
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for the sync word, everything else ignored
// HEADER | expecting a frame header or the desync word
// DATA   | loading NumRows words into FrameData, strobe on the last one
// DROP   | discarding NumRows words of an out-of-range frame
module frame_strobe_ctrl #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4
) (
  input  logic                                 CLK,
  input  logic                                 resetn,
  input  logic [31:0]                          WriteData,
  input  logic                                 WriteStrobe,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 ConfigBusy,
  output logic                                 ConfigError
);

  localparam int CntW = $clog2(NumRows) + 1;
  localparam logic [CntW-1:0] LastRow = CntW'(NumRows - 1);
  localparam logic [31:0] SyncWord   = 32'hFAB0_FAB1;
  localparam logic [31:0] DesyncWord = 32'hFAB0_FAB0;
  localparam logic [MaxFramesPerCol-1:0] StrobeOne =
    {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DROP} state_t;

  state_t          state;
  logic [CntW-1:0] row_cnt;
  logic [4:0]      frame_idx;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      row_cnt     <= '0;
      frame_idx   <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      ConfigBusy  <= 1'b0;
      ConfigError <= 1'b0;
    end else begin
      // Strobe is a one-cycle pulse; it drops on the next edge whether or
      // not a word arrives, so a header in the strobe cycle is harmless.
      FrameStrobe <= '0;
      if (WriteStrobe) begin
        case (state)
          IDLE: begin
            if (WriteData == SyncWord) begin
              state      <= HEADER;
              ConfigBusy <= 1'b1;
            end
          end
          HEADER: begin
            if (WriteData == DesyncWord) begin
              state      <= IDLE;
              ConfigBusy <= 1'b0;
            end else if (WriteData[31:24] == 8'hC0) begin
              row_cnt <= '0;
              if ({27'd0, WriteData[20:16]} < 32'(MaxFramesPerCol)) begin
                frame_idx <= WriteData[20:16];
                state     <= DATA;
              end else begin
                ConfigError <= 1'b1;
                state       <= DROP;
              end
            end else begin
              ConfigError <= 1'b1;
              ConfigBusy  <= 1'b0;
              state       <= IDLE;
            end
          end
          DATA: begin
            for (int k = 0; k < NumRows; k++) begin
              if (row_cnt == CntW'(k))
                FrameData[k*FrameBitsPerRow +: FrameBitsPerRow] <= WriteData;
            end
            row_cnt <= row_cnt + 1'b1;
            // Final row and strobe land on the same edge, so FrameData is
            // already complete and stable for the whole strobe window.
            if (row_cnt == LastRow) begin
              FrameStrobe <= StrobeOne << frame_idx;
              state       <= HEADER;
            end
          end
          DROP: begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == LastRow)
              state <= HEADER;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_strobe_ctrl.sv
module tb_frame_strobe_ctrl;

  logic         CLK;
  logic         resetn;
  logic [31:0]  WriteData;
  logic         WriteStrobe;
  logic [127:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         ConfigBusy;
  logic         ConfigError;

  int n_chk;
  int n_err;

  logic [19:0]  strobe_log[$];
  logic [127:0] data_log[$];

  frame_strobe_ctrl #(
    .MaxFramesPerCol(20),
    .FrameBitsPerRow(32),
    .NumRows(4)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .WriteData(WriteData),
    .WriteStrobe(WriteStrobe),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .ConfigBusy(ConfigBusy),
    .ConfigError(ConfigError)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Record every strobe cycle with the data visible during it.
  always @(negedge CLK) begin
    if (resetn && FrameStrobe != 20'h0) begin
      chk("onehot", 128'($countones(FrameStrobe)), 128'd1);
      strobe_log.push_back(FrameStrobe);
      data_log.push_back(FrameData);
    end
  end

  // All drive tasks are entered at a falling edge and leave at one.
  task automatic drive(input logic [31:0] w);
    WriteData   = w;
    WriteStrobe = 1'b1;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    WriteStrobe = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_gap(input logic [31:0] w);
    idle(int'($urandom_range(0, 2)));
    drive(w);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},   FrameData,          128'h0);
    chk({tag, "_strobe"}, 128'(FrameStrobe),  128'h0);
    chk({tag, "_busy"},   128'(ConfigBusy),   128'h0);
    chk({tag, "_err"},    128'(ConfigError),  128'h0);
  endtask

  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic [31:0]  fa [4];
  logic [31:0]  fb [4];
  logic [127:0] exp_a, exp_b, exp_d;

  initial begin
    n_chk = 0;
    n_err = 0;
    fa = '{32'hA0A0_0001, 32'hA1A1_0002, 32'hA2A2_0003, 32'hA3A3_0004};
    fb = '{32'hB0B0_1000, 32'hB1B1_2000, 32'hB2B2_3000, 32'hB3B3_4000};
    exp_a = {fa[3], fa[2], fa[1], fa[0]};
    exp_b = {fb[3], fb[2], fb[1], fb[0]};
    exp_d = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;

    // Reset values
    resetn      = 1'b0;
    WriteStrobe = 1'b0;
    WriteData   = 32'h0;
    repeat (3) @(negedge CLK);
    chk_all_zero("in_reset");
    resetn = 1'b1;
    @(negedge CLK);
    chk_all_zero("after_reset");
    drive(32'h1234_5678);
    drive(32'hC003_0000);
    idle(2);
    chk("nosync_busy", 128'(ConfigBusy), 128'h0);
    chk("nosync_strobes", 128'(strobe_log.size()), 128'd0);

    // Single frame, exact strobe timing
    drive(SYNC);
    chk("sync_busy", 128'(ConfigBusy), 128'h1);
    drive(32'hC005_0000);
    drive(32'h1111_1111);
    drive(32'h2222_2222);
    drive(32'h3333_3333);
    drive(32'h4444_4444);
    WriteStrobe = 1'b0;
    chk("single_strobe", 128'(FrameStrobe), 128'h00020);
    chk("single_data", FrameData, 128'h44444444_33333333_22222222_11111111);
    @(negedge CLK);
    chk("single_strobe_off", 128'(FrameStrobe), 128'h0);
    idle(1);
    chk("single_count", 128'(strobe_log.size()), 128'd1);
    strobe_log.delete();
    data_log.delete();

    // Back-to-back frames 0 and 19 with random gaps; frame 19 header lands
    // directly in the frame 0 strobe cycle.
    drive_gap(32'hC000_0000);
    for (int i = 0; i < 4; i++) drive_gap(fa[i]);
    drive(32'hC013_0000);
    for (int i = 0; i < 4; i++) drive_gap(fb[i]);
    idle(3);
    chk("b2b_count", 128'(strobe_log.size()), 128'd2);
    if (strobe_log.size() == 2) begin
      chk("b2b_strobe0", 128'(strobe_log[0]), 128'h00001);
      chk("b2b_data0", data_log[0], exp_a);
      chk("b2b_strobe1", 128'(strobe_log[1]), 128'h80000);
      chk("b2b_data1", data_log[1], exp_b);
    end
    strobe_log.delete();
    data_log.delete();

    // Out-of-range frame index 20
    drive(32'hC014_0000);
    chk("oor_err", 128'(ConfigError), 128'h1);
    drive(32'hC1C1_C1C1);
    drive(SYNC);
    drive(32'hC3C3_C3C3);
    drive(32'hC4C4_C4C4);
    idle(2);
    chk("oor_nostrobe", 128'(strobe_log.size()), 128'd0);
    chk("oor_data_kept", FrameData, exp_b);
    chk("oor_busy", 128'(ConfigBusy), 128'h1);
    drive(32'hC003_0000);
    drive(32'hD0D0_D0D0);
    drive(32'hD1D1_D1D1);
    drive(32'hD2D2_D2D2);
    drive(32'hD3D3_D3D3);
    WriteStrobe = 1'b0;
    chk("f3_strobe", 128'(FrameStrobe), 128'h00008);
    chk("f3_data", FrameData, exp_d);
    @(negedge CLK);
    strobe_log.delete();
    data_log.delete();

    // Reset clears the sticky error; then desync and bad header
    resetn = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    chk("rst_err_clear", 128'(ConfigError), 128'h0);
    drive(SYNC);
    chk("ds_busy_up", 128'(ConfigBusy), 128'h1);
    drive(DESYNC);
    chk("ds_busy_down", 128'(ConfigBusy), 128'h0);
    chk("ds_no_err", 128'(ConfigError), 128'h0);
    drive(SYNC);
    drive(32'hDEAD_BEEF);
    chk("bad_hdr_err", 128'(ConfigError), 128'h1);
    chk("bad_hdr_idle", 128'(ConfigBusy), 128'h0);
    drive(32'hC002_0000);
    for (int i = 0; i < 4; i++) drive(fa[i]);
    idle(2);
    chk("bad_hdr_ignored", 128'(strobe_log.size()), 128'd0);
    chk("bad_hdr_data", FrameData, 128'h0);
    chk("bad_hdr_busy", 128'(ConfigBusy), 128'h0);

    // Reset mid-frame
    resetn = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    drive(SYNC);
    drive(32'hC007_0000);
    drive(fb[0]);
    drive(fb[1]);
    WriteStrobe = 1'b0;
    chk("partial_data", FrameData, {64'h0, fb[1], fb[0]});
    resetn = 1'b0;
    @(negedge CLK);
    chk_all_zero("mid_rst");
    resetn = 1'b1;
    idle(3);
    chk("mid_rst_nostrobe", 128'(strobe_log.size()), 128'd0);
    chk("mid_rst_busy", 128'(ConfigBusy), 128'h0);
    drive(SYNC);
    drive(32'hC007_0000);
    for (int i = 0; i < 4; i++) drive(fa[i]);
    WriteStrobe = 1'b0;
    chk("reload_strobe", 128'(FrameStrobe), 128'h00080);
    chk("reload_data", FrameData, exp_a);
    @(negedge CLK);
    chk("reload_strobe_off", 128'(FrameStrobe), 128'h0);
    idle(1);
    chk("reload_count", 128'(strobe_log.size()), 128'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/frame_strobe_ctrl.md
# frame_strobe_ctrl

Column configuration controller that turns a 32-bit configuration word stream into the `FrameData` and one-hot `FrameStrobe` signals that daisy-chain up a fabric column. It sits at the bottom of the column and drives `FrameStrobe[MaxFramesPerCol-1:0]` into the first tile. That strobe then passes through every tile's strobe buffers up to the N-terminal tile, which ends the chain. Each accepted frame causes exactly one single-cycle strobe pulse, qualified by stable frame data.

## Interface
- `MaxFramesPerCol`, 20: number of frames per column; the width of `FrameStrobe`.
- `FrameBitsPerRow`, 32: frame bits per tile row; equal to the config word width.
- `NumRows`, 4: tile rows in the column. Data words per frame = `NumRows`.
- `CLK`: input, 1 bit. Configuration clock; every register is rising-edge.
- `resetn`: input, 1 bit. Asynchronous, active-low reset.
- `WriteData`: input, 32 bits. Configuration word.
- `WriteStrobe`: input, 1 bit. `WriteData` is valid this cycle. There is no backpressure; a valid word is always consumed.
- `FrameData`: output, `NumRows*FrameBitsPerRow` bits. Row data; row k occupies bits `[k*32 +: 32]`.
- `FrameStrobe`: output, `MaxFramesPerCol` bits. One-hot single-cycle write pulse.
- `ConfigBusy`: output, 1 bit. High when the state is not IDLE.
- `ConfigError`: output, 1 bit. Sticky bad-header or frame-range error.

## Operation
- States: IDLE, HEADER, DATA, DROP.
- **IDLE:** waits for `WriteData == 32'hFAB0_FAB1` (sync) with `WriteStrobe`, then goes to HEADER. Any other word is ignored.
- **HEADER:**
  - Frame header: `WriteData[31:24] == 8'hC0`. The frame index is `WriteData[20:16]`; all other bits are don't-care.
  - If the index is below `MaxFramesPerCol`: latch the index, clear the row counter, go to DATA.
  - If the index is `MaxFramesPerCol` or more: set `ConfigError`, go to DROP.
  - Desync word `32'hFAB0_FAB0`: go to IDLE. No error.
  - Any other word: set `ConfigError`, go to IDLE.
- **DATA:**
  - Each accepted word is written into `FrameData` row = row counter, then the counter increments. Counter width is `$clog2(NumRows)+1`.
  - On the word that completes row `NumRows-1`, the next edge pulses `FrameStrobe[index]` and the state returns to HEADER.
  - Rows not yet written keep their previous values. `FrameData` is never cleared between frames.
- **DROP:** consumes exactly `NumRows` words without touching `FrameData` and without any strobe, then returns to HEADER.
- Cycles with `WriteStrobe` low change nothing and never advance a state.
- A sync word inside DATA or DROP is treated as data.
- `ConfigError` clears only on reset.
- Reset mid-frame: the partial frame is abandoned, no strobe is issued, and the state is IDLE.

## Timing
- Reset values: `FrameData` = 0, `FrameStrobe` = 0, `ConfigBusy` = 0, `ConfigError` = 0, state = IDLE.
- All outputs are registered.
- A word sampled on edge t is visible on `FrameData` after edge t.
- Last data word sampled on edge t:
  - The final row is updated after edge t.
  - `FrameStrobe[index]` is high from edge t to edge t+1, then returns to 0.
  - `FrameData` is stable for that whole window.
- A header word may arrive in the strobe cycle (edge t+1). It is accepted normally, and the strobe still deasserts.
- Back-to-back frames: the minimum is 1 header + `NumRows` words per strobe, and no idle cycles are required.
- At most one `FrameStrobe` bit is high in any cycle.
- `ConfigBusy` rises the cycle after sync is accepted and falls the cycle after desync is accepted.
- `ConfigError` rises the cycle after the offending header is accepted.

## Test plan
- **Reset values:** hold `resetn` low, then release. Check all outputs are 0 and the state is IDLE. Send words `0x12345678` and `0xC0030000` without sync: no strobe, and `ConfigBusy` stays 0.
- **Single frame:** send sync, header `0xC0050000`, then data `0x11111111`, `0x22222222`, `0x33333333`, `0x44444444`. Require `FrameData == 128'h44444444_33333333_22222222_11111111`. `FrameStrobe` must equal `20'h00020` for exactly one cycle, one cycle after the last data word.
- **Back-to-back frames with gaps:** send frames 0 and 19 with random `WriteStrobe` gaps inside them. Require strobes `20'h00001` then `20'h80000`, one cycle each, with no overlap. Data must match the words sent for each frame.
- **Out-of-range frame:** send header `0xC0140000` (index 20) followed by 4 data words. `ConfigError` must be 1. There must be no strobe and `FrameData` must be unchanged. A following valid frame-3 header must still produce a `20'h00008` strobe.
- **Desync and bad header:**
  - Sending desync must drop `ConfigBusy` to 0.
  - Then send sync followed by `0xDEADBEEF`: `ConfigError` must be 1 and the state must be IDLE. The next data word must be ignored.
- **Reset mid-frame:** assert `resetn` low after 2 of 4 data words. Require no strobe, all outputs 0, and that a full frame loaded afterwards behaves correctly.
